// File: rtl/doa_acc_sequencer_if.sv
// Stream and result bus between the upstream ADC/FFT framing, the sequencer and the DOA core.
interface doa_acc_sequencer_if #(
    parameter int unsigned DIN_WIDTH = 16,
    parameter int unsigned IDX_WIDTH = 6
);
    // Upstream samples
    logic [DIN_WIDTH-1:0] din1_re;
    logic [DIN_WIDTH-1:0] din1_im;
    logic [DIN_WIDTH-1:0] din2_re;
    logic [DIN_WIDTH-1:0] din2_im;
    logic                 din_valid;
    logic                 sync_in;

    // Gated samples towards the DOA core
    logic [DIN_WIDTH-1:0] dout1_re;
    logic [DIN_WIDTH-1:0] dout1_im;
    logic [DIN_WIDTH-1:0] dout2_re;
    logic [DIN_WIDTH-1:0] dout2_im;
    logic                 dout_valid;
    logic                 new_acc;

    // Results coming back from the DOA core and the qualified result strobe
    logic                 res_valid_in;
    logic                 res_error_in;
    logic                 res_valid;
    logic [IDX_WIDTH-1:0] res_idx;

    modport master (
        output din1_re, din1_im, din2_re, din2_im, din_valid, sync_in,
        output res_valid_in, res_error_in,
        input  dout1_re, dout1_im, dout2_re, dout2_im, dout_valid, new_acc,
        input  res_valid, res_idx
    );

    modport slave (
        input  din1_re, din1_im, din2_re, din2_im, din_valid, sync_in,
        input  res_valid_in, res_error_in,
        output dout1_re, dout1_im, dout2_re, dout2_im, dout_valid, new_acc,
        output res_valid, res_idx
    );
endinterface

// File: rtl/doa_acc_sequencer.sv
// Sequencer for the pointwise DOA datapath: aligns the framed stream to vector
// boundaries, gates valids, issues new_acc per integration, and tags/checks results.
// VECTOR_LEN must be a power of two, at least 2.
module doa_acc_sequencer #(
    parameter int unsigned DIN_WIDTH     = 16,
    parameter int unsigned VECTOR_LEN    = 64,
    parameter int unsigned ACC_LEN_WIDTH = 16,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_enable,
    input  logic [ACC_LEN_WIDTH-1:0] cfg_acc_len,
    input  logic                     cfg_valid,
    doa_acc_sequencer_if.slave       dp,
    output logic                     sync_err,
    output logic                     missing_err,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic                     busy
);
    localparam int unsigned IDX_WIDTH = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
    localparam logic [IDX_WIDTH-1:0] SAMP_LAST = IDX_WIDTH'(VECTOR_LEN - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        INTEG     = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;

    // samp_idx is the index the next accepted sample takes within its vector
    logic [IDX_WIDTH-1:0]     samp_idx;
    logic [IDX_WIDTH-1:0]     samp_idx_nxt;
    logic [ACC_LEN_WIDTH-1:0] vec_cnt;
    logic [ACC_LEN_WIDTH-1:0] vec_cnt_nxt;
    logic [ACC_LEN_WIDTH-1:0] acc_len;
    logic [ACC_LEN_WIDTH-1:0] acc_len_eff;
    logic [ACC_LEN_WIDTH-1:0] pend_len;
    logic                     pend_vld;
    logic [ACC_LEN_WIDTH-1:0] pend_len_in;
    logic                     pend_vld_in;

    // supp: results belong to the uninitialised first dump after a resync
    logic                     supp;
    logic [IDX_WIDTH-1:0]     res_cnt;
    logic [IDX_WIDTH-1:0]     res_cnt_inc;
    logic                     res_count;

    logic                     samp_wrap;
    logic                     vec_wrap;
    logic                     fwd;
    logic                     fwd_new_acc;
    logic                     apply_cfg;
    logic                     first_start;
    logic                     vec0_start;
    logic                     supp_set;
    logic                     sync_err_set;

    // Derived values shared by the FSM and the result tracker
    always_comb begin
        acc_len_eff = (acc_len == '0) ? ACC_LEN_WIDTH'(1) : acc_len;
        samp_wrap   = (samp_idx == SAMP_LAST);
        vec_wrap    = (vec_cnt == acc_len_eff - ACC_LEN_WIDTH'(1));
        pend_len_in = cfg_valid ? cfg_acc_len : pend_len;
        pend_vld_in = cfg_valid | pend_vld;
        res_count   = dp.res_valid_in & ~supp;
        // A result arriving with the vector-0 check is counted first
        res_cnt_inc = res_cnt + IDX_WIDTH'(res_count);
    end

    // Next-state, sample gating and boundary events
    always_comb begin
        state_nxt    = state;
        samp_idx_nxt = samp_idx;
        vec_cnt_nxt  = vec_cnt;
        fwd          = 1'b0;
        fwd_new_acc  = 1'b0;
        apply_cfg    = 1'b0;
        first_start  = 1'b0;
        vec0_start   = 1'b0;
        supp_set     = 1'b0;
        sync_err_set = 1'b0;

        case (state)
            IDLE: begin
                apply_cfg = 1'b1;
                if (cfg_enable) begin
                    state_nxt = WAIT_SYNC;
                    supp_set  = 1'b1;
                end
            end

            WAIT_SYNC: begin
                apply_cfg = 1'b1;
                if (!cfg_enable) begin
                    state_nxt = IDLE;
                end else if (dp.din_valid && dp.sync_in) begin
                    state_nxt    = INTEG;
                    fwd          = 1'b1;
                    fwd_new_acc  = 1'b1;
                    first_start  = 1'b1;
                    samp_idx_nxt = IDX_WIDTH'(1);
                    vec_cnt_nxt  = '0;
                end
            end

            INTEG: begin
                if (dp.din_valid) begin
                    if (dp.sync_in && (samp_idx != '0)) begin
                        // Misaligned sync: drop the sample and realign
                        sync_err_set = 1'b1;
                        supp_set     = 1'b1;
                        state_nxt    = WAIT_SYNC;
                    end else begin
                        fwd          = 1'b1;
                        fwd_new_acc  = (vec_cnt == '0);
                        vec0_start   = (samp_idx == '0) && (vec_cnt == '0);
                        samp_idx_nxt = samp_wrap ? '0 : samp_idx + IDX_WIDTH'(1);
                        if (samp_wrap) begin
                            vec_cnt_nxt = vec_wrap ? '0 : vec_cnt + ACC_LEN_WIDTH'(1);
                            apply_cfg   = vec_wrap;
                            if (!cfg_enable) begin
                                state_nxt = IDLE;
                            end
                        end
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control state: FSM, counters, integration length, result count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            samp_idx <= '0;
            vec_cnt  <= '0;
            acc_len  <= ACC_LEN_WIDTH'(1);
            pend_len <= '0;
            pend_vld <= 1'b0;
            supp     <= 1'b1;
            res_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            samp_idx <= samp_idx_nxt;
            vec_cnt  <= vec_cnt_nxt;
            if (apply_cfg && pend_vld_in) begin
                acc_len  <= pend_len_in;
                pend_len <= pend_len_in;
                pend_vld <= 1'b0;
            end else begin
                pend_len <= pend_len_in;
                pend_vld <= pend_vld_in;
            end
            if (supp_set) begin
                supp <= 1'b1;
            end else if (vec0_start) begin
                supp <= 1'b0;
            end
            res_cnt <= (first_start || vec0_start) ? '0 : res_cnt_inc;
        end
    end

    // Registered outputs: gated stream, result tag, sticky flags, error count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp.dout1_re   <= '0;
            dp.dout1_im   <= '0;
            dp.dout2_re   <= '0;
            dp.dout2_im   <= '0;
            dp.dout_valid <= 1'b0;
            dp.new_acc    <= 1'b0;
            dp.res_valid  <= 1'b0;
            dp.res_idx    <= '0;
            sync_err      <= 1'b0;
            missing_err   <= 1'b0;
            err_count     <= '0;
            busy          <= 1'b0;
        end else begin
            if (fwd) begin
                dp.dout1_re <= dp.din1_re;
                dp.dout1_im <= dp.din1_im;
                dp.dout2_re <= dp.din2_re;
                dp.dout2_im <= dp.din2_im;
            end
            dp.dout_valid <= fwd;
            dp.new_acc    <= fwd_new_acc;
            dp.res_valid  <= res_count;
            if (res_count) begin
                dp.res_idx <= res_cnt;
            end
            if (sync_err_set) begin
                sync_err <= 1'b1;
            end
            if (vec0_start && (res_cnt_inc != '0)) begin
                missing_err <= 1'b1;
            end
            if (res_count && dp.res_error_in && (err_count != '1)) begin
                err_count <= err_count + ERR_CNT_WIDTH'(1);
            end
            busy <= (state_nxt != IDLE);
        end
    end
endmodule

// File: tb/tb_doa_acc_sequencer.sv
// Randomized bench for doa_acc_sequencer with a scoreboard fed by an integration-level model.
module tb_doa_acc_sequencer;
    localparam int unsigned DW      = 16;
    localparam int unsigned VL      = 4;
    localparam int unsigned IW      = 2;
    localparam int unsigned AW      = 16;
    localparam int unsigned EW      = 8;
    localparam int          ERR_MAX = (1 << EW) - 1;

    typedef struct {
        int          tag;
        logic [DW-1:0] d1r, d1i, d2r, d2i;
        logic        na;
    } sexp_t;

    typedef struct {
        int tag;
        int idx;
    } rexp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_enable = 1'b0;
    logic [AW-1:0] cfg_acc_len = '0;
    logic          cfg_valid = 1'b0;
    logic          sync_err;
    logic          missing_err;
    logic [EW-1:0] err_count;
    logic          busy;

    doa_acc_sequencer_if #(.DIN_WIDTH(DW), .IDX_WIDTH(IW)) dp ();

    doa_acc_sequencer #(
        .DIN_WIDTH(DW), .VECTOR_LEN(VL), .ACC_LEN_WIDTH(AW), .ERR_CNT_WIDTH(EW)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_enable(cfg_enable), .cfg_acc_len(cfg_acc_len), .cfg_valid(cfg_valid),
        .dp(dp),
        .sync_err(sync_err), .missing_err(missing_err), .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int errors = 0;
    int checks = 0;

    sexp_t sq[$];
    rexp_t rq[$];

    // Reference model: integration position k counts samples since the integration began
    int m_mode;      // 0 idle, 1 waiting for sync, 2 integrating
    int m_k, m_L, m_pend, m_pend_v, m_supp, m_rcnt, m_sync_err, m_miss, m_err;
    bit m_start_ev;

    // Stimulus knobs
    int  up_pos, p_valid, p_res, p_err, res_left, n_next;
    bit  bad_sync_req, short_next, cv_req, en;
    logic [AW-1:0] cal_req;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_L = 1; m_pend = 0; m_pend_v = 0;
        m_supp = 1; m_rcnt = 0; m_sync_err = 0; m_miss = 0; m_err = 0;
        up_pos = 0; res_left = 0;
    endtask

    task automatic model_apply();
        if (m_pend_v != 0) begin
            m_L = m_pend;
            m_pend_v = 0;
        end
    endtask

    task automatic model_step(input bit dv, input bit sy, input bit cv, input int cal,
                              input bit rv, input bit re, input logic [DW-1:0] a,
                              input logic [DW-1:0] b, input logic [DW-1:0] c,
                              input logic [DW-1:0] d, input int tag);
        bit    fwd, na, last;
        int    leff;
        sexp_t se;
        fwd = 0; na = 0; m_start_ev = 0;
        if (rv && m_supp == 0) begin
            rq.push_back('{tag: tag, idx: m_rcnt});
            m_rcnt = (m_rcnt + 1) % VL;
            if (re && m_err < ERR_MAX) m_err++;
        end
        if (cv) begin
            m_pend = cal;
            m_pend_v = 1;
        end
        case (m_mode)
            0: begin
                model_apply();
                if (en) begin m_mode = 1; m_supp = 1; end
            end
            1: begin
                model_apply();
                if (!en) m_mode = 0;
                else if (dv && sy) begin
                    m_mode = 2; m_k = 1; m_rcnt = 0; fwd = 1; na = 1; m_start_ev = 1;
                end
            end
            default: begin
                if (dv) begin
                    if (sy && (m_k % VL) != 0) begin
                        m_sync_err = 1; m_mode = 1; m_supp = 1;
                    end else begin
                        leff = (m_L == 0) ? 1 : m_L;
                        if (m_k == 0) begin
                            if (m_rcnt != 0) m_miss = 1;
                            m_rcnt = 0; m_supp = 0; m_start_ev = 1;
                        end
                        fwd  = 1;
                        na   = (m_k < VL);
                        last = ((m_k % VL) == VL - 1);
                        m_k++;
                        if (m_k == VL * leff) begin
                            m_k = 0;
                            model_apply();
                        end
                        if (last && !en) m_mode = 0;
                    end
                end
            end
        endcase
        if (fwd) begin
            se.tag = tag; se.d1r = a; se.d1i = b; se.d2r = c; se.d2i = d; se.na = na;
            sq.push_back(se);
        end
    endtask

    // One clock of stimulus: drive at posedge+1, update the model, return after the capture edge
    task automatic cycle();
        bit dv, sy, rv, re, cv;
        logic [DW-1:0] a, b, c, d;
        dv = ($urandom_range(99) < p_valid);
        sy = dv && ((up_pos % VL) == 0);
        if (dv && bad_sync_req && m_mode == 2 && (m_k % VL) == 2) begin
            sy = 1; bad_sync_req = 0;
        end
        if (dv) up_pos++;
        rv = (res_left > 0) && ($urandom_range(99) < p_res);
        if (rv) res_left--;
        re = ($urandom_range(99) < p_err);
        cv = cv_req; cv_req = 0;
        a = DW'($urandom); b = DW'($urandom); c = DW'($urandom); d = DW'($urandom);
        dp.din1_re = a; dp.din1_im = b; dp.din2_re = c; dp.din2_im = d;
        dp.din_valid = dv; dp.sync_in = sy;
        dp.res_valid_in = rv; dp.res_error_in = re;
        cfg_valid = cv; cfg_acc_len = cal_req; cfg_enable = en;
        model_step(dv, sy, cv, int'(cal_req), rv, re, a, b, c, d, edge_cnt + 1);
        if (m_start_ev) begin
            res_left += short_next ? VL - 1 : n_next;
            short_next = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic status(input string tagname);
        chk({tagname, "_sync_err"}, sync_err, m_sync_err);
        chk({tagname, "_missing_err"}, missing_err, m_miss);
        chk({tagname, "_err_count"}, err_count, m_err);
        chk({tagname, "_busy"}, busy, m_mode != 0);
    endtask

    // Stream monitor: every expected sample must appear exactly one edge after it was driven
    always @(negedge clk) begin
        sexp_t se;
        if (!rst) begin
            if (sq.size() > 0 && sq[0].tag <= edge_cnt) begin
                se = sq.pop_front();
                checks++;
                if (!dp.dout_valid || se.tag != edge_cnt || dp.new_acc !== se.na ||
                    dp.dout1_re !== se.d1r || dp.dout1_im !== se.d1i ||
                    dp.dout2_re !== se.d2r || dp.dout2_im !== se.d2i) begin
                    errors++;
                    $display("FAIL stream: got v=%b na=%b d=%h/%h/%h/%h expected v=1 na=%b d=%h/%h/%h/%h due edge %0d at edge %0d",
                             dp.dout_valid, dp.new_acc, dp.dout1_re, dp.dout1_im, dp.dout2_re, dp.dout2_im,
                             se.na, se.d1r, se.d1i, se.d2r, se.d2i, se.tag, edge_cnt);
                end
            end else if (dp.dout_valid || dp.new_acc) begin
                checks++;
                errors++;
                $display("FAIL stream_unexpected: got v=%b na=%b expected v=0 na=0 at edge %0d",
                         dp.dout_valid, dp.new_acc, edge_cnt);
            end
        end
    end

    // Result monitor: qualified results carry the pre-increment bin index
    always @(negedge clk) begin
        rexp_t re_;
        if (!rst) begin
            if (rq.size() > 0 && rq[0].tag <= edge_cnt) begin
                re_ = rq.pop_front();
                checks++;
                if (!dp.res_valid || re_.tag != edge_cnt || int'(dp.res_idx) != re_.idx) begin
                    errors++;
                    $display("FAIL result: got v=%b idx=%0d expected v=1 idx=%0d due edge %0d at edge %0d",
                             dp.res_valid, dp.res_idx, re_.idx, re_.tag, edge_cnt);
                end
            end else if (dp.res_valid) begin
                checks++;
                errors++;
                $display("FAIL result_unexpected: got v=1 idx=%0d expected v=0 at edge %0d",
                         dp.res_idx, edge_cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200us");
        $fatal(1, "timeout");
    end

    initial begin
        dp.din1_re = '0; dp.din1_im = '0; dp.din2_re = '0; dp.din2_im = '0;
        dp.din_valid = 0; dp.sync_in = 0; dp.res_valid_in = 0; dp.res_error_in = 0;
        model_reset();
        en = 0; cv_req = 0; cal_req = '0; bad_sync_req = 0; short_next = 0;
        p_valid = 100; p_res = 75; p_err = 30; n_next = VL;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout_valid", dp.dout_valid, 0);
        chk("rst_new_acc", dp.new_acc, 0);
        chk("rst_res_valid", dp.res_valid, 0);
        chk("rst_dout1_re", dp.dout1_re, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_count", err_count, 0);
        rst = 0;

        // acc_len=2, continuous valid, sync every vector
        cal_req = AW'(2); cv_req = 1; en = 1;
        repeat (48) cycle();
        status("a");

        // Misaligned sync at sample 2
        bad_sync_req = 1;
        repeat (24) cycle();
        status("b");
        chk("b_sync_err_const", sync_err, 1);

        // One short dump of VL-1 results
        short_next = 1;
        repeat (24) cycle();
        status("c");

        // Length change to 3 mid-integration, sparse valids
        p_valid = 70;
        cal_req = AW'(3); cv_req = 1;
        repeat (80) cycle();
        status("d");

        // acc_len=0 behaves as one vector per integration
        cal_req = AW'(0); cv_req = 1;
        repeat (40) cycle();
        status("e");

        // Disable takes effect at the next vector wrap, then re-enable
        en = 0;
        repeat (16) cycle();
        status("f");
        en = 1;
        repeat (20) cycle();

        // Error counter saturation
        p_valid = 100; p_res = 100; p_err = 100;
        repeat (340) cycle();
        status("g");
        chk("g_err_sat_const", err_count, ERR_MAX);

        // Asynchronous reset mid-vector
        p_res = 75; p_err = 30;
        repeat (6) cycle();
        dp.din_valid = 0; dp.sync_in = 0; dp.res_valid_in = 0; cfg_valid = 0;
        rst = 1;
        #1;
        chk("arst_dout_valid", dp.dout_valid, 0);
        chk("arst_new_acc", dp.new_acc, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err_count", err_count, 0);
        chk("arst_sync_err", sync_err, 0);
        sq.delete();
        rq.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;

        // Restart after reset with acc_len=2
        p_valid = 80;
        cal_req = AW'(2); cv_req = 1;
        repeat (40) cycle();
        status("i");

        // Drain
        p_valid = 0; p_res = 0; res_left = 0;
        repeat (4) cycle();
        chk("drain_stream_q", sq.size(), 0);
        chk("drain_result_q", rq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
